fetch_stage: RTL

Instruction-fetch stage of the five-stage pipelined MIPS core, sitting directly upstream of the IF/ID consumers (decode, hazard unit) inside `Top`. It owns the program counter and drives the instruction-memory address. It registers the fetched word into the IF/ID pipeline register and handles load-use stalls, jump redirects resolved in ID and branch redirects resolved in EX. It also keeps fetch and stall performance counters that the simulation bench reads at `$finish`.

---
 rtl/fetch_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the five-stage pipelined MIPS core.
//               Owns the program counter, drives the instruction-memory
//               address and registers the fetched word into IF/ID. Handles
//               load-use stalls, jump redirects (resolved in ID) and branch
//               redirects (resolved in EX), and keeps fetch/stall counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W        PC / address width in bits
//   RESET_PC      PC after reset (word aligned)
//   CNT_W         performance counter width
// Ports
//   clk           pipeline clock, rising edge
//   reset         asynchronous active-low reset
//   stall         load-use hold from the hazard unit
//   jump          jump resolved in ID, destination jump_target
//   branch_taken  taken branch resolved in EX, destination branch_target
//   imem_addr     byte address to instruction memory (current PC)
//   imem_data     instruction word read combinationally at imem_addr
//   ifid_inst     registered instruction (0 = NOP bubble)
//   ifid_pc_plus4 registered PC+4 of ifid_inst
//   ifid_valid    1 = ifid_inst is a real fetched instruction
//   fetch_count   instructions loaded into IF/ID with valid=1 (wraps)
//   stall_count   cycles held by stall (wraps)
// ============================================================================
module fetch_stage #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic              ifid_valid,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [CNT_W-1:0]  stall_count
);

    // Word-alignment mask applied to redirect targets.
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ifid_inst;
    logic [ADDR_W-1:0] r_ifid_pc_plus4;
    logic              r_ifid_valid;
    logic [CNT_W-1:0]  r_fetch_count;
    logic [CNT_W-1:0]  r_stall_count;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_pc;
    logic [ADDR_W-1:0] w_jump_pc;

    // Modulo 2^ADDR_W: the top word wraps to address 0.
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_branch_pc = branch_target & c_ALIGN_MASK;
    assign w_jump_pc   = jump_target   & c_ALIGN_MASK;

    // Priority: branch (older instruction, in EX) beats jump (in ID), and
    // any redirect beats a stall since the stalled slot is squashed anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc            <= RESET_PC;
            r_ifid_inst     <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
            r_fetch_count   <= '0;
            r_stall_count   <= '0;
        end else if (branch_taken) begin
            // Flush: insert a NOP bubble, pc_plus4 deliberately held.
            r_pc         <= w_branch_pc;
            r_ifid_inst  <= '0;
            r_ifid_valid <= 1'b0;
        end else if (jump) begin
            r_pc         <= w_jump_pc;
            r_ifid_inst  <= '0;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end else begin
            r_pc            <= w_pc_plus4;
            r_ifid_inst     <= imem_data;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
            r_fetch_count   <= r_fetch_count + CNT_W'(1);
        end
    end

    // Memory address comes straight from the PC register, no extra stage.
    assign imem_addr     = r_pc;
    assign ifid_inst     = r_ifid_inst;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;
    assign fetch_count   = r_fetch_count;
    assign stall_count   = r_stall_count;

endmodule
`default_nettype wire
